// File: rtl/mon_mem_arb_if.sv
// rtl/mon_mem_arb_if.sv - bundle of requester, memory and error signals around mon_mem_arb
interface mon_mem_arb_if;
   logic        m_read_req;
   logic        m_write_req;
   logic [31:0] m_adr;
   logic [31:0] m_wdata;
   logic        m_read_valid;
   logic        m_write_finish;
   logic [31:0] m_rdata;
   logic        c_read_req;
   logic        c_write_req;
   logic [31:0] c_adr;
   logic [31:0] c_wdata;
   logic        c_read_valid;
   logic        c_write_finish;
   logic [31:0] c_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        err_tmo;
   logic        err_src;
   logic        err_clr;

   modport slave (
      input  m_read_req, m_write_req, m_adr, m_wdata,
      input  c_read_req, c_write_req, c_adr, c_wdata,
      input  mem_ack, mem_rdata, err_clr,
      output m_read_valid, m_write_finish, m_rdata,
      output c_read_valid, c_write_finish, c_rdata,
      output mem_req, mem_we, mem_adr, mem_wdata,
      output err_tmo, err_src
   );

   modport master (
      output m_read_req, m_write_req, m_adr, m_wdata,
      output c_read_req, c_write_req, c_adr, c_wdata,
      output mem_ack, mem_rdata, err_clr,
      input  m_read_valid, m_write_finish, m_rdata,
      input  c_read_valid, c_write_finish, c_rdata,
      input  mem_req, mem_we, mem_adr, mem_wdata,
      input  err_tmo, err_src
   );
endinterface

// File: rtl/mon_mem_arb.sv
// rtl/mon_mem_arb.sv - two-requester memory arbiter with timeout abort
module mon_mem_arb #(
   parameter int TMO      = 1024,
   parameter int TMO_W    = 11,
   parameter int MON_PRIO = 0
) (
   input  logic         clk,
   input  logic         rst,
   mon_mem_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

   state_t           state_q, state_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             last_grant_q, last_grant_d;
   logic             gnt_q, gnt_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_adr_q, mem_adr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             m_read_valid_q, m_read_valid_d;
   logic             m_write_finish_q, m_write_finish_d;
   logic             c_read_valid_q, c_read_valid_d;
   logic             c_write_finish_q, c_write_finish_d;
   logic [31:0]      m_rdata_q, m_rdata_d;
   logic [31:0]      c_rdata_q, c_rdata_d;
   logic             err_tmo_q, err_tmo_d;
   logic             err_src_q, err_src_d;

   logic             m_act, c_act, pick_c, sel_we, timed_out, finish;
   logic [31:0]      sel_adr, sel_wdata, rdata_res;

   always_comb begin
      m_act     = bus.m_read_req | bus.m_write_req;
      c_act     = bus.c_read_req | bus.c_write_req;
      // last_grant: 0 = monitor, 1 = CPU; a contested grant goes to the other one
      pick_c    = c_act & (~m_act | ((MON_PRIO == 0) & ~last_grant_q));
      sel_we    = pick_c ? bus.c_write_req : bus.m_write_req;
      sel_adr   = pick_c ? bus.c_adr : bus.m_adr;
      sel_wdata = pick_c ? bus.c_wdata : bus.m_wdata;
      timed_out = (cnt_q == TMO_W'(TMO - 1));
      finish    = bus.mem_ack | timed_out;
      rdata_res = bus.mem_ack ? bus.mem_rdata : 32'hDEAD_BEEF;

      state_d          = state_q;
      cnt_d            = cnt_q;
      last_grant_d     = last_grant_q;
      gnt_d            = gnt_q;
      mem_req_d        = mem_req_q;
      mem_we_d         = mem_we_q;
      mem_adr_d        = mem_adr_q;
      mem_wdata_d      = mem_wdata_q;
      m_read_valid_d   = 1'b0;
      m_write_finish_d = 1'b0;
      c_read_valid_d   = 1'b0;
      c_write_finish_d = 1'b0;
      m_rdata_d        = m_rdata_q;
      c_rdata_d        = c_rdata_q;
      err_tmo_d        = err_tmo_q & ~bus.err_clr;
      err_src_d        = err_src_q;

      case (state_q)
         IDLE: begin
            if (m_act | c_act) begin
               gnt_d        = pick_c;
               last_grant_d = pick_c;
               mem_req_d    = 1'b1;
               mem_we_d     = sel_we;
               mem_adr_d    = sel_adr;
               mem_wdata_d  = sel_wdata;
               cnt_d        = '0;
               state_d      = sel_we ? WR_WAIT : RD_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (finish) begin
               mem_req_d = 1'b0;
               state_d   = DONE;
               if (state_q == RD_WAIT) begin
                  if (gnt_q) begin
                     c_rdata_d      = rdata_res;
                     c_read_valid_d = 1'b1;
                  end else begin
                     m_rdata_d      = rdata_res;
                     m_read_valid_d = 1'b1;
                  end
               end else begin
                  c_write_finish_d = gnt_q;
                  m_write_finish_d = ~gnt_q;
               end
               // an ack on the last counted cycle still completes normally
               if (!bus.mem_ack) begin
                  err_tmo_d = 1'b1;
                  err_src_d = gnt_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         last_grant_q     <= 1'b1;
         gnt_q            <= 1'b0;
         mem_req_q        <= 1'b0;
         mem_we_q         <= 1'b0;
         mem_adr_q        <= '0;
         mem_wdata_q      <= '0;
         m_read_valid_q   <= 1'b0;
         m_write_finish_q <= 1'b0;
         c_read_valid_q   <= 1'b0;
         c_write_finish_q <= 1'b0;
         m_rdata_q        <= '0;
         c_rdata_q        <= '0;
         err_tmo_q        <= 1'b0;
         err_src_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         last_grant_q     <= last_grant_d;
         gnt_q            <= gnt_d;
         mem_req_q        <= mem_req_d;
         mem_we_q         <= mem_we_d;
         mem_adr_q        <= mem_adr_d;
         mem_wdata_q      <= mem_wdata_d;
         m_read_valid_q   <= m_read_valid_d;
         m_write_finish_q <= m_write_finish_d;
         c_read_valid_q   <= c_read_valid_d;
         c_write_finish_q <= c_write_finish_d;
         m_rdata_q        <= m_rdata_d;
         c_rdata_q        <= c_rdata_d;
         err_tmo_q        <= err_tmo_d;
         err_src_q        <= err_src_d;
      end
   end

   assign bus.mem_req        = mem_req_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_adr        = mem_adr_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.m_read_valid   = m_read_valid_q;
   assign bus.m_write_finish = m_write_finish_q;
   assign bus.m_rdata        = m_rdata_q;
   assign bus.c_read_valid   = c_read_valid_q;
   assign bus.c_write_finish = c_write_finish_q;
   assign bus.c_rdata        = c_rdata_q;
   assign bus.err_tmo        = err_tmo_q;
   assign bus.err_src        = err_src_q;
endmodule

// File: doc/mon_mem_arb.md
# mon_mem_arb

Two-requester memory access arbiter placed between the UART monitor's memory read/write request port, the CPU-side data request port, and the single shared memory port. It serialises read and write transactions, alternates grants fairly (or gives the monitor fixed priority), and aborts any transaction whose memory acknowledge never arrives, reporting the abort through sticky error flags. One transaction is outstanding at a time.

## Interface
- TMO, default 1024: timeout in cycles, counted in a wait state; legal range 2..2^TMO_W-1.
- TMO_W, default 11: width of the timeout counter.
- MON_PRIO, default 0: 0 = round-robin; 1 = monitor always wins a contested grant.
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_read_req / m_write_req  in  1  monitor read / write request, level, held until done.
- m_adr  in  32  monitor address, stable while request is high.
- m_wdata  in  32  monitor write data.
- m_read_valid  out  1  one-cycle pulse; m_rdata valid in the same cycle.
- m_write_finish  out  1  one-cycle pulse at write completion.
- m_rdata  out  32  read data, held until the next monitor read completes.
- c_read_req, c_write_req, c_adr, c_wdata, c_read_valid, c_write_finish, c_rdata: CPU side, same widths and rules.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read; stable with mem_req.
- mem_adr / mem_wdata  out  32  registered copy of the granted requester's address/data.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  32  read data, valid with mem_ack.
- err_tmo  out  1  sticky: a transaction timed out.
- err_src  out  1  requester of the most recent timeout (0 = monitor, 1 = CPU).
- err_clr  in  1  clears err_tmo.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE: requester active = read_req | write_req. None active: stay. One active: grant it. Both active: MON_PRIO=1 -> monitor; else grant the requester not in last_grant. last_grant resets to CPU, so the first contested grant goes to the monitor.
- Within one requester, read_req and write_req both high: write served first; read stays pending.
- Grant: capture adr/wdata/type into mem_adr/mem_wdata/mem_we, set mem_req, update last_grant, load counter with 0, go RD_WAIT or WR_WAIT.
- WAIT: counter increments each cycle. mem_ack: drop mem_req; for a read register mem_rdata into granted x_rdata; pulse done; go DONE. Counter reaching TMO-1 without ack: drop mem_req, x_rdata = 32'hDEADBEEF for reads, pulse done, set err_tmo, err_src = granted id; go DONE.
- mem_ack in the same cycle as timeout: ack wins, no error.
- DONE: one cycle, no arbitration; then IDLE. Requesters must drop their request by the edge ending the done cycle.
- err_clr and a new timeout in the same cycle: set wins.
- mem_ack outside WAIT ignored.

## Timing
- All outputs registered. Reset: all outputs 0 (m_rdata, c_rdata, mem_adr, mem_wdata = 0), state IDLE, counter 0, last_grant = CPU.
- Request sampled at edge N in IDLE -> mem_req high from N+1.
- mem_ack sampled at edge M -> mem_req low and done pulse/rdata from M+1; DONE during M+1; next grant earliest at edge M+2 -> mem_req at M+3.
- Minimum turnaround: 3 cycles per transaction with zero-wait memory (ack the cycle after mem_req).
- Timeout: mem_req high exactly TMO cycles, then done pulse.
- rst asserted mid-transaction: mem_req and pulses drop immediately; no done pulse; pending requester must re-request.

## Test plan
- Monitor read adr 0x0000_0040, memory acks 1 cycle after mem_req with 0x1234_5678 -> mem_we=0, mem_adr=0x40, m_read_valid one cycle with m_rdata=0x1234_5678, c_* idle.
- Monitor and CPU write requests both held, MON_PRIO=0 -> grants monitor, CPU, monitor, CPU on repeat; with MON_PRIO=1 -> monitor every time while held.
- Monitor read_req and write_req both high -> write issued first (mem_we=1), read after finish+DONE.
- No mem_ack, TMO=16, CPU read -> mem_req high exactly 16 cycles, c_read_valid with c_rdata=0xDEADBEEF, err_tmo=1, err_src=1; err_clr -> err_tmo=0.
- mem_ack on the final timeout cycle -> normal completion, err_tmo stays 0; err_clr coincident with a timeout -> err_tmo=1.
- rst pulse while in WR_WAIT -> mem_req=0 asynchronously, no m_write_finish, state IDLE, first contested grant after release goes to monitor.
